// File: rtl/sm_arith_pkg.sv
// Purpose: shared sign-magnitude arithmetic types, opcodes and field helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest word the helpers and payload can carry; instances use the low bits.
  localparam int SM_W_MAX = 64;

  // Ordered operands handed from the order stage to the compute stage.
  typedef struct packed {
    logic [SM_W_MAX-2:0] mag_large;
    logic [SM_W_MAX-2:0] mag_small;
    logic                sign;
    logic                is_add;
  } sm_payload_t;

  // Sign bit of an n-bit sign-magnitude word (zero-extended into w).
  function automatic logic sm_sign(input logic [SM_W_MAX-1:0] w, input int n);
    return w[n-1];
  endfunction

  // Magnitude field (low n-1 bits) of an n-bit sign-magnitude word.
  function automatic logic [SM_W_MAX-2:0] sm_mag(input logic [SM_W_MAX-1:0] w, input int n);
    logic [SM_W_MAX-1:0] mask;
    mask = (SM_W_MAX'(1) << (n - 1)) - SM_W_MAX'(1);
    return (SM_W_MAX-1)'(w & mask);
  endfunction

endpackage

// File: rtl/sm_order_stage.sv
// Purpose: S1 of the add/sub pipe; resolves effective op and orders magnitudes.
// Latency: 1 cycle from acceptance to s1_vld.
// Backpressure: holds its entry until s1_adv; o_ready = !s1_vld || s1_adv.
module sm_order_stage
  import sm_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        o_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic        in_op,
  output logic        s1_vld,
  output sm_payload_t s1_dat,
  input  logic        s1_adv
);

  logic                sa;
  logic                sb_eff;
  logic [SM_W_MAX-2:0] ma;
  logic [SM_W_MAX-2:0] mb;
  sm_payload_t         nxt_dat;
  logic                accept;

  assign o_ready = !s1_vld || s1_adv;
  assign accept  = in_valid && o_ready;

  // Effective sign of B, then put the larger magnitude first for subtracts.
  always_comb begin
    sa      = sm_sign(SM_W_MAX'(in_a), N);
    sb_eff  = sm_sign(SM_W_MAX'(in_b), N) ^ (in_op == OP_SUB);
    ma      = sm_mag(SM_W_MAX'(in_a), N);
    mb      = sm_mag(SM_W_MAX'(in_b), N);
    nxt_dat = '0;
    nxt_dat.is_add = (sa == sb_eff);
    if (nxt_dat.is_add || (ma >= mb)) begin
      nxt_dat.mag_large = ma;
      nxt_dat.mag_small = mb;
      nxt_dat.sign      = sa;
    end else begin
      nxt_dat.mag_large = mb;
      nxt_dat.mag_small = ma;
      nxt_dat.sign      = sb_eff;
    end
  end

  // Stage register: load on accept, drain when S2 takes the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_dat <= nxt_dat;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Purpose: 2-stage sign-magnitude add/sub; SM_ADDSUB_SATURATE_EN clamps overflowed magnitudes.
// Latency: 2 cycles from acceptance to o_valid, 1 op/cycle.
// Backpressure: output held while o_valid && !in_ready; o_ready combinational from in_ready.
module sm_addsub_pipe
  import sm_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         o_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_op,
  output logic         o_valid,
  input  logic         in_ready,
  output logic [N-1:0] o_out,
  output logic         o_carry
);

  logic        s1_vld;
  sm_payload_t s1_dat;
  logic        s2_ld;

  logic [N-2:0] mag_large;
  logic [N-2:0] mag_small;
  logic [N-1:0] sum;
  logic [N-2:0] diff;
  logic [N-2:0] mag_res;
  logic         carry;
  logic         sign_res;
  logic         unused_hi;

  // S2 can take a new entry when empty or when its result is being consumed.
  assign s2_ld = !o_valid || in_ready;

  sm_order_stage #(.N(N)) u_order (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .o_ready  (o_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .s1_vld   (s1_vld),
    .s1_dat   (s1_dat),
    .s1_adv   (s2_ld)
  );

  // Payload fields are sized for the widest word; only the low N-1 bits carry data.
  assign unused_hi = (|(s1_dat.mag_large >> (N - 1))) | (|(s1_dat.mag_small >> (N - 1)));

  // Magnitude add/subtract, overflow handling and zero-sign normalisation.
  always_comb begin
    mag_large = s1_dat.mag_large[N-2:0];
    mag_small = s1_dat.mag_small[N-2:0];
    sum       = {1'b0, mag_large} + {1'b0, mag_small};
    diff      = mag_large - mag_small;
    carry     = s1_dat.is_add & sum[N-1];
`ifdef SM_ADDSUB_SATURATE_EN
    if (carry) begin
      mag_res = '1;
    end else begin
      mag_res = s1_dat.is_add ? sum[N-2:0] : diff;
    end
`else
    mag_res = s1_dat.is_add ? sum[N-2:0] : diff;
`endif
    sign_res = s1_dat.sign && (mag_res != '0);
  end

  // Output register: result and carry only change when S2 loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_out   <= '0;
      o_carry <= 1'b0;
    end else if (s2_ld) begin
      o_valid <= s1_vld;
      if (s1_vld) begin
        o_out   <= {sign_res, mag_res};
        o_carry <= carry;
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Purpose: directed self-checking bench for sm_addsub_pipe (N=8).
// Latency: expects results 2 cycles after acceptance when unstalled.
// Backpressure: exercises in_ready stalls and async reset with a full pipe.
module tb_sm_addsub_pipe;

  localparam int N = 8;

`ifdef SM_ADDSUB_SATURATE_EN
  localparam logic [7:0] OVF_POS  = 8'h7F;
  localparam logic [7:0] OVF_NEG  = 8'hFF;
  localparam logic [7:0] OVF_7F7F = 8'h7F;
`else
  localparam logic [7:0] OVF_POS  = 8'h00;
  localparam logic [7:0] OVF_NEG  = 8'h00;
  localparam logic [7:0] OVF_7F7F = 8'h7E;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] exp;
    logic       cy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         o_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_op;
  logic         o_valid;
  logic         in_ready;
  logic [N-1:0] o_out;
  logic         o_carry;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .o_ready  (o_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .o_valid  (o_valid),
    .in_ready (in_ready),
    .o_out    (o_out),
    .o_carry  (o_carry)
  );

  // Issue one op into an idle pipe and wait (bounded) for its result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                       output logic [7:0] res, output logic cy, output int lat,
                       output logic got);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; in_ready = 1'b1;
    got = 1'b0; res = '0; cy = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (o_valid) begin
        got = 1'b1; res = o_out; cy = o_carry;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_out !== 8'h00) begin n_err++; $display("FAIL reset o_out: got %h want 00", o_out); end
    n_cmp++; if (o_carry !== 1'b0) begin n_err++; $display("FAIL reset o_carry: got %b want 0", o_carry); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset o_ready: got %b want 1", o_ready); end
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    logic [7:0] res;
    logic       cy;
    int         lat;
    logic       got;
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, res, cy, lat, got);
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL %s[%0d] timeout: no o_valid within budget", name, i);
      end else begin
        if (res !== tbl[i].exp) begin n_err++; $display("FAIL %s[%0d] o_out: got %h want %h", name, i, res, tbl[i].exp); end
        n_cmp++;
        if (cy !== tbl[i].cy) begin n_err++; $display("FAIL %s[%0d] o_carry: got %b want %b", name, i, cy, tbl[i].cy); end
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL %s[%0d] latency: got %0d want 2", name, i, lat); end
      end
    end
  endtask

  task automatic test_basic();
    vec_t tbl[$];
    tbl = '{
      '{8'h05, 8'h03, 1'b1, 8'h02, 1'b0},
      '{8'h03, 8'h05, 1'b1, 8'h82, 1'b0},
      '{8'h85, 8'h05, 1'b0, 8'h00, 1'b0},
      '{8'h85, 8'h85, 1'b1, 8'h00, 1'b0},
      '{8'h83, 8'h82, 1'b0, 8'h85, 1'b0},
      '{8'h05, 8'h85, 1'b1, 8'h0A, 1'b0},
      '{8'h80, 8'h00, 1'b1, 8'h00, 1'b0}
    };
    run_table("basic", tbl);
  endtask

  task automatic test_overflow();
    vec_t tbl[$];
    tbl = '{
      '{8'h7F, 8'h01, 1'b0, OVF_POS, 1'b1},
      '{8'hFF, 8'h81, 1'b0, OVF_NEG, 1'b1},
      '{8'h7F, 8'h81, 1'b1, OVF_POS, 1'b1},
      '{8'h40, 8'h40, 1'b0, OVF_POS, 1'b1}
    };
    run_table("ovf", tbl);
  endtask

  task automatic test_back_to_back();
    vec_t tbl[4];
    tbl = '{
      '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0},
      '{8'h10, 8'h20, 1'b1, 8'h90, 1'b0},
      '{8'h7F, 8'h7F, 1'b0, OVF_7F7F, 1'b1},
      '{8'h81, 8'h01, 1'b1, 8'h82, 1'b0}
    };
    in_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] o_ready: got %b want 1", i, o_ready); end
      if (i >= 2) begin
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] o_valid: got %b want 1", i, o_valid); end
        n_cmp++; if (o_out !== tbl[i-2].exp) begin n_err++; $display("FAIL b2b[%0d] o_out: got %h want %h", i, o_out, tbl[i-2].exp); end
        n_cmp++; if (o_carry !== tbl[i-2].cy) begin n_err++; $display("FAIL b2b[%0d] o_carry: got %b want %b", i, o_carry, tbl[i-2].cy); end
      end
    end
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b drain o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq[3];
    exp_seq = '{8'h02, 8'h04, 8'h06};
    in_ready = 1'b0;
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h01; in_op = 1'b0; in_valid = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp accept1 o_ready: got %b want 1", o_ready); end
    @(negedge clk);
    in_a = 8'h02; in_b = 8'h02;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp accept2 o_ready: got %b want 1", o_ready); end
    @(negedge clk);
    in_a = 8'h03; in_b = 8'h03;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp stall[%0d] o_ready: got %b want 0", i, o_ready); end
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp stall[%0d] o_valid: got %b want 1", i, o_valid); end
      n_cmp++; if (o_out !== 8'h02) begin n_err++; $display("FAIL bp stall[%0d] o_out: got %h want 02", i, o_out); end
      @(negedge clk);
    end
    in_ready = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp release o_ready: got %b want 1", o_ready); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp drain[%0d] o_valid: got %b want 1", i, o_valid); end
      n_cmp++; if (o_out !== exp_seq[i]) begin n_err++; $display("FAIL bp drain[%0d] o_out: got %h want %h", i, o_out, exp_seq[i]); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp empty o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_async_reset();
    in_ready = 1'b0;
    @(negedge clk);
    in_a = 8'h11; in_b = 8'h22; in_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 8'h33; in_b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL arst pre o_valid: got %b want 1", o_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_out !== 8'h00) begin n_err++; $display("FAIL arst o_out: got %h want 00", o_out); end
    n_cmp++; if (o_carry !== 1'b0) begin n_err++; $display("FAIL arst o_carry: got %b want 0", o_carry); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL arst o_ready: got %b want 1", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst stale[%0d] o_valid: got %b want 0", i, o_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
Pipelined sign-magnitude add/subtract unit and the parametrised successor of the combinational sign-magnitude subtractor. Handles both add and subtract, selected per operation. Has a configurable data width and a valid/ready handshake on each side. Operands use the codebase's sign-magnitude format: the MSB is the sign (1 = negative) and the lower N-1 bits are the magnitude. Sits between the operand source and the result consumer in the arithmetic datapath.

Parameters:
N, 8, total word width in bits (sign + N-1 magnitude bits); must be >= 2.

Ports:
clk  input  1  clock; all flops on rising edge.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  upstream operand valid.
o_ready  output  1  block can accept an operation this cycle.
in_a  input  N  operand A, sign-magnitude.
in_b  input  N  operand B, sign-magnitude.
in_op  input  1  0 = A+B, 1 = A-B.
o_valid  output  1  result valid.
in_ready  input  1  downstream ready.
o_out  output  N  result, sign-magnitude.
o_carry  output  1  magnitude overflow of this result.

Behaviour:
- Transfers: input accepted when in_valid && o_ready; output consumed when o_valid && in_ready.
- Structure: two register stages, S1 (order) and S2 (compute). Latency is 2 cycles from acceptance to o_valid when not stalled. Throughput is 1 operation per cycle.
- S1:
  - Effective B sign: sb' = sign(B) XOR in_op.
  - Registers: larger magnitude, smaller magnitude, result sign, is_add = (sign(A) == sb').
  - Magnitude ordering:
    - If is_add: sign = sign(A), no swap.
    - Else if mag(A) >= mag(B): sign = sign(A).
    - Else: swap operands, sign = sb'.
- S2:
  - Magnitude = large + small when is_add, otherwise large − small.
  - o_carry = bit N-1 of the add. It is always 0 for subtract.
  - Magnitude is truncated to N-1 bits.
- Zero normalisation: a zero result magnitude forces sign 0, so −0 is never produced. −0 inputs are treated as zero.
- Stall rules:
  - S2 loads when it is empty or in_ready = 1.
  - S1 advances when S2 loads.
  - o_ready = !S1.valid || S2 loads. This is combinational from in_ready; no combinational path from in_valid to o_ready.
- Output stability: o_out and o_carry are held stable while o_valid && !in_ready.
- Results always leave in acceptance order.
- Simultaneous events: input accept, S1→S2 move and output consume can all occur in the same cycle without a bubble.
- Reset: asynchronous assertion clears both valid flags, all data registers, o_out, o_carry and o_valid to 0. Operations in flight are discarded.
- Out of reset: o_ready = 1.

Optional Feature:
SM_ADDSUB_SATURATE_EN
- Defined: on overflow, the magnitude is forced to all ones and the sign is kept; o_carry is still 1. Example with N=8: +127 + 1 → 0x7F, carry 1.
- Undefined: the magnitude wraps modulo 2^(N-1) and zero normalisation applies to the wrapped value.

Decomposition:
- Package sm_arith_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - Parametrised functions sm_sign() and sm_mag(), replacing the sign/magnitude field macros.
  - S1→S2 payload struct: {large, small, sign, is_add}.
- Natural sub-module: sm_order_stage, the S1 compare/swap register stage with its handshake. sm_addsub_pipe instantiates it and adds S2.

Test Plan:
All cases use N=8 and default build unless stated; results appear 2 cycles after acceptance unless stalled.
1. in_op=1, in_a=0x05, in_b=0x03 → o_out=0x02, o_carry=0.
2. in_op=1, in_a=0x03, in_b=0x05 → o_out=0x82 (−2), o_carry=0.
3. in_op=0, in_a=0x85, in_b=0x05 → o_out=0x00 (not 0x80). Same for in_op=1, a=b=0x85 → 0x00.
4. in_op=0, in_a=0x7F, in_b=0x01 → o_out=0x00, o_carry=1. With SM_ADDSUB_SATURATE_EN defined → o_out=0x7F, o_carry=1.
5. Backpressure: in_ready=0 while 3 back-to-back ops (+1+1, +2+2, +3+3) are offered → o_ready drops after 2 accepts and o_out holds 0x02. On release, results 0x02, 0x04, 0x06 appear on consecutive cycles, in order.
6. Assert rst_n low mid-cycle with S1 and S2 both valid → o_valid=0, o_out=0x00, o_carry=0 immediately, without waiting for a clock edge; no stale result after release.
